// File: rtl/image_write_pkg.sv
// Shared cfg-map and state encodings for the image write-back stage.
package image_write_pkg;

  // cfg bus register map
  localparam int unsigned CFG_IW_IMG_W  = 16;
  localparam int unsigned CFG_IW_IMG_DH = 17;
  localparam int unsigned CFG_IW_BASE   = 18;

  // iterations of the shift-add plane multiplier (one per operand bit)
  localparam int unsigned MUL_STEPS = 16;

  typedef enum logic [1:0] {
    IW_IDLE,
    IW_CALC,
    IW_READY,
    IW_ACTIVE
  } iw_state_t;

endpackage

// File: rtl/image_write_mul.sv
// Sequential 16x16 shift-add multiplier: operands latched on start,
// product valid when done pulses MUL_STEPS cycles later.
module image_write_mul
  import image_write_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [31:0] product
);

  logic [31:0] a_sh;
  logic [15:0] b_sh;
  logic [4:0]  cnt;
  logic        busy;

  // Add the shifted multiplicand for each set multiplier bit, LSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_sh    <= {16'd0, a};
        b_sh    <= b;
        cnt     <= '0;
        busy    <= 1'b1;
        product <= '0;
      end else if (busy) begin
        if (b_sh[0]) product <= product + a_sh;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + 5'd1;
        if (cnt == 5'(MUL_STEPS - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/image_write.sv
// Image write-back stage: turns the depth-innermost result stream into
// memory writes at base + d*plane + h*W + w, one registered write per beat.
module image_write
  import image_write_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned GROUP_NB   = 4,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned MEM_AWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic                          next,
  output logic                          next_rdy,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] result_bus,
  input  logic                          result_last,
  input  logic                          result_val,
  output logic                          result_rdy,
  output logic                          wr_val,
  output logic [MEM_AWIDTH-1:0]         wr_addr,
  output logic [GROUP_NB*IMG_WIDTH-1:0] wr_data,
  output logic                          wr_last,
  output logic                          err
);

  iw_state_t state;

  logic [15:0]           w_m1, h_m1, d_m1;
  logic [MEM_AWIDTH-1:0] base;

  logic                  mul_start, mul_done;
  logic [31:0]           mul_prod, plane_full;
  logic [MEM_AWIDTH-1:0] plane, d_off, pix_addr;
  logic [15:0]           d_cnt;
  logic [31:0]           pix_cnt;

  logic cfg_hit, cfg_open, accept, final_beat;

  assign cfg_hit = cfg_valid &&
                   (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W)  ||
                    cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_DH) ||
                    cfg_addr == CFG_AWIDTH'(CFG_IW_BASE));
  assign cfg_open   = (state == IW_IDLE) || (state == IW_READY);
  assign next_rdy   = (state == IW_READY);
  assign result_rdy = (state == IW_ACTIVE);
  assign accept     = result_val && result_rdy;
  assign final_beat = (d_cnt == d_m1) && (pix_cnt == plane_full - 32'd1);
  assign plane      = plane_full[MEM_AWIDTH-1:0];

  // cfg registers, writable only while no layer is being set up or streamed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_m1 <= '0;
      h_m1 <= '0;
      d_m1 <= '0;
      base <= '0;
    end else if (cfg_valid && cfg_open) begin
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_W)) w_m1 <= cfg_data[15:0];
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_IMG_DH)) begin
        d_m1 <= cfg_data[31:16];
        h_m1 <= cfg_data[15:0];
      end
      if (cfg_addr == CFG_AWIDTH'(CFG_IW_BASE)) base <= cfg_data[MEM_AWIDTH-1:0];
    end
  end

  // mul_start is registered so the multiplier sees the just-written cfg values
  image_write_mul u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (w_m1 + 16'd1),
    .b       (h_m1 + 16'd1),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Layer FSM with incremental address counters and the registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IW_IDLE;
      mul_start  <= 1'b0;
      plane_full <= '0;
      d_cnt      <= '0;
      pix_cnt    <= '0;
      d_off      <= '0;
      pix_addr   <= '0;
      wr_val     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_last    <= 1'b0;
      err        <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      wr_val    <= 1'b0;
      wr_last   <= 1'b0;
      unique case (state)
        IW_IDLE: begin
          if (cfg_hit) begin
            state     <= IW_CALC;
            mul_start <= 1'b1;
          end
        end
        IW_CALC: begin
          if (mul_done) begin
            state      <= IW_READY;
            plane_full <= mul_prod;
          end
        end
        IW_READY: begin
          if (cfg_hit) begin
            state     <= IW_CALC;
            mul_start <= 1'b1;
          end else if (next) begin
            state    <= IW_ACTIVE;
            err      <= 1'b0;
            d_cnt    <= '0;
            pix_cnt  <= '0;
            d_off    <= '0;
            pix_addr <= base;
          end
        end
        IW_ACTIVE: begin
          if (accept) begin
            wr_val  <= 1'b1;
            wr_addr <= pix_addr + d_off;
            wr_data <= result_bus;
            wr_last <= final_beat;
            if (result_last != final_beat) err <= 1'b1;
            // depth is innermost: plane stride per beat, pixel step on depth wrap
            if (d_cnt == d_m1) begin
              d_cnt    <= '0;
              d_off    <= '0;
              pix_cnt  <= pix_cnt + 32'd1;
              pix_addr <= pix_addr + MEM_AWIDTH'(1);
            end else begin
              d_cnt <= d_cnt + 16'd1;
              d_off <= d_off + plane;
            end
            if (final_beat) state <= IW_READY;
          end
        end
      endcase
    end
  end

endmodule
